// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding request, single-entry instruction hold,
// and a return-address stack that serves call/ret redirects from decode.
module fetch_unit #(
    parameter int          STACK_DEPTH = 8,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        jump_en,
    input  logic        call_en,
    input  logic        ret_en,
    input  logic        halt_en,
    input  logic [15:0] target,
    output logic        halted,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;

    localparam logic [SP_W-1:0] SP_ZERO = {SP_W{1'b0}};
    localparam logic [SP_W-1:0] SP_ONE  = {{(SP_W-1){1'b0}}, 1'b1};
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]       state_r;
    logic [15:0]      pc_r;
    logic [15:0]      instr_r;
    logic [15:0]      instr_pc_r;
    logic [SP_W-1:0]  sp_r;
    logic [15:0]      stack_r [STACK_DEPTH];
    logic             imem_req_r;
    logic [15:0]      imem_addr_r;
    logic             instr_valid_r;
    logic             halted_r;
    logic             overflow_r;
    logic             underflow_r;

    logic [1:0]       state_s;
    logic [15:0]      pc_s;
    logic [15:0]      instr_s;
    logic [15:0]      instr_pc_s;
    logic [SP_W-1:0]  sp_s;
    logic             push_s;
    logic             overflow_s;
    logic             underflow_s;
    logic [15:0]      seq_pc_s;
    logic [SP_W-1:0]  sp_dec_s;
    logic [IDX_W-1:0] push_idx_s;
    logic [IDX_W-1:0] top_idx_s;

    // Address arithmetic shared by sequential advance, call push and return pop
    always_comb begin
        seq_pc_s   = instr_pc_r + 16'h0001;
        sp_dec_s   = sp_r - SP_ONE;
        push_idx_s = sp_r[IDX_W-1:0];
        top_idx_s  = sp_dec_s[IDX_W-1:0];
    end

    // Next-state logic; redirects only matter on the HOLD cycle that consumes
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        instr_s     = instr_r;
        instr_pc_s  = instr_pc_r;
        sp_s        = sp_r;
        push_s      = 1'b0;
        overflow_s  = overflow_r;
        underflow_s = underflow_r;
        case (state_r)
            ST_FETCH: begin
                if (imem_valid) begin
                    instr_s    = imem_rdata;
                    instr_pc_s = pc_r;
                    state_s    = ST_HOLD;
                end else begin
                    state_s    = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (stall) begin
                    state_s = ST_HOLD;
                end else if (halt_en) begin
                    state_s = ST_HALTED;
                end else if (ret_en) begin
                    if (sp_r == SP_ZERO) begin
                        underflow_s = 1'b1;
                        state_s     = ST_HALTED;
                    end else begin
                        pc_s    = stack_r[top_idx_s];
                        sp_s    = sp_dec_s;
                        state_s = ST_FETCH;
                    end
                end else if (call_en) begin
                    // A full stack cannot record the return, so fetch stops rather than lose it
                    if (sp_r == SP_FULL) begin
                        overflow_s = 1'b1;
                        state_s    = ST_HALTED;
                    end else begin
                        push_s  = 1'b1;
                        sp_s    = sp_r + SP_ONE;
                        pc_s    = target;
                        state_s = ST_FETCH;
                    end
                end else if (jump_en) begin
                    pc_s    = target;
                    state_s = ST_FETCH;
                end else begin
                    pc_s    = seq_pc_s;
                    state_s = ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_s = ST_HALTED;
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // Control state and registered output copies derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_PC;
            instr_r       <= 16'h0000;
            instr_pc_r    <= 16'h0000;
            sp_r          <= SP_ZERO;
            overflow_r    <= 1'b0;
            underflow_r   <= 1'b0;
            imem_req_r    <= 1'b1;
            imem_addr_r   <= RESET_PC;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            instr_r       <= instr_s;
            instr_pc_r    <= instr_pc_s;
            sp_r          <= sp_s;
            overflow_r    <= overflow_s;
            underflow_r   <= underflow_s;
            imem_req_r    <= (state_s == ST_FETCH);
            imem_addr_r   <= pc_s;
            instr_valid_r <= (state_s == ST_HOLD);
            halted_r      <= (state_s == ST_HALTED);
        end
    end

    // Return-address storage; an entry is only written by a successful call
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= 16'h0000;
            end
        end else if (push_s) begin
            stack_r[push_idx_s] <= seq_pc_s;
        end else begin
            stack_r[push_idx_s] <= stack_r[push_idx_s];
        end
    end

    assign imem_req        = imem_req_r;
    assign imem_addr       = imem_addr_r;
    assign instr           = instr_r;
    assign instr_pc        = instr_pc_r;
    assign instr_valid     = instr_valid_r;
    assign halted          = halted_r;
    assign stack_overflow  = overflow_r;
    assign stack_underflow = underflow_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the memory returns addr ^ 16'h5A5A, expected
// fetch addresses are queued by the directed sequence and popped by a monitor.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        stall;
    logic        jump_en;
    logic        call_en;
    logic        ret_en;
    logic        halt_en;
    logic [15:0] target;
    logic        halted;
    logic        stack_overflow;
    logic        stack_underflow;

    int          n_cmp;
    int          n_err;
    logic        mem_on;
    logic        spurious;
    logic [15:0] exp_q [$];

    fetch_unit #(.STACK_DEPTH(8), .RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_valid      (imem_valid),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .jump_en         (jump_en),
        .call_en         (call_en),
        .ret_en          (ret_en),
        .halt_en         (halt_en),
        .target          (target),
        .halted          (halted),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Zero-wait memory: answers the current request shortly after each edge
    initial begin
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            imem_valid = spurious || (mem_on && imem_req);
            imem_rdata = spurious ? 16'hBEEF : (imem_addr ^ 16'h5A5A);
        end
    end

    // Monitor: each newly presented instruction must match the queue head
    initial begin
        logic        prev_v;
        logic [15:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (instr_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_instr: got pc %h, expected none", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", {16'h0000, instr_pc}, {16'h0000, e});
                    check("instr", {16'h0000, instr}, {16'h0000, e ^ 16'h5A5A});
                end
            end
            prev_v = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic wait_pc(input logic [15:0] pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == pc) found = 1'b1;
        end
        check("wait_pc_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic redirect(input logic [15:0] at_pc, input logic j, input logic c,
                            input logic r, input logic h, input logic [15:0] tgt);
        wait_pc(at_pc);
        jump_en = j;
        call_en = c;
        ret_en  = r;
        halt_en = h;
        target  = tgt;
        @(posedge clk);
        #1;
        jump_en = 1'b0;
        call_en = 1'b0;
        ret_en  = 1'b0;
        halt_en = 1'b0;
        target  = 16'h0000;
    endtask

    task automatic do_reset();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_imem_req", imem_req, 1'b1);
        check("rst_imem_addr", imem_addr, 16'h0000);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_flags", {stack_overflow, stack_underflow}, 2'b00);
        check("rst_instr", {instr, instr_pc}, 32'h0000_0000);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        stall    = 1'b0;
        jump_en  = 1'b0;
        call_en  = 1'b0;
        ret_en   = 1'b0;
        halt_en  = 1'b0;
        target   = 16'h0000;
        mem_on   = 1'b1;
        spurious = 1'b0;

        // Sequential stream 0..3 with one instruction every two cycles
        do_reset();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0003);
        wait_pc(16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("valid_rhythm", instr_valid, (i % 2 == 1) ? 1'b1 : 1'b0);
        end
        exp_q.push_back(16'h0010);
        redirect(16'h0003, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);

        // Stall for three cycles with a bogus redirect and stray memory strobe
        wait_pc(16'h0010);
        stall    = 1'b1;
        jump_en  = 1'b1;
        target   = 16'h0077;
        spurious = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_instr_pc", instr_pc, 16'h0010);
            check("stall_instr", instr, 16'h5A4A);
            check("stall_valid", {instr_valid, imem_req}, 2'b10);
        end
        stall    = 1'b0;
        spurious = 1'b0;
        target   = 16'h0040;
        exp_q.push_back(16'h0040);
        @(posedge clk);
        #1;
        jump_en = 1'b0;
        check("jump_addr", imem_addr, 16'h0040);
        check("jump_req", imem_req, 1'b1);

        // Call 0x0005 -> 0x0100, return from 0x0102 -> 0x0006
        exp_q.push_back(16'h0005);
        redirect(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0101);
        exp_q.push_back(16'h0102);
        redirect(16'h0005, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
        check("call_addr", imem_addr, 16'h0100);
        exp_q.push_back(16'h0006);
        redirect(16'h0102, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("ret_addr", imem_addr, 16'h0006);

        // Halt wins over a simultaneous jump; nothing is fetched afterwards
        redirect(16'h0006, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0200);
        spurious = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("halt_state", {halted, imem_req, instr_valid}, 3'b100);
        end
        spurious = 1'b0;
        check("halt_flags", {stack_overflow, stack_underflow}, 2'b00);

        // Sequential wrap from 0xFFFF to 0x0000
        do_reset();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hFFFF);
        redirect(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        exp_q.push_back(16'h0000);
        redirect(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("wrap_addr", imem_addr, 16'h0000);
        wait_pc(16'h0000);

        // Nine nested calls: the ninth overflows an eight-entry stack
        do_reset();
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(16'((i + 1) * 16));
            redirect(16'(i * 16), 1'b0, 1'b1, 1'b0, 1'b0, 16'((i + 1) * 16));
        end
        check("ovf_flags", {stack_overflow, stack_underflow}, 2'b10);
        check("ovf_halt", {halted, imem_req, instr_valid}, 3'b100);
        repeat (3) @(negedge clk);
        check("ovf_sticky", {stack_overflow, halted, imem_req}, 3'b110);

        // Return on an empty stack underflows
        do_reset();
        exp_q.push_back(16'h0000);
        redirect(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("unf_flags", {stack_overflow, stack_underflow}, 2'b01);
        check("unf_halt", {halted, imem_req, instr_valid}, 3'b100);

        // Reset while waiting on memory at 0x0033 with one stacked return
        do_reset();
        exp_q.push_back(16'h0000);
        wait_pc(16'h0000);
        mem_on  = 1'b0;
        call_en = 1'b1;
        target  = 16'h0033;
        @(posedge clk);
        #1;
        call_en = 1'b0;
        target  = 16'h0000;
        repeat (3) @(negedge clk);
        check("wait_req", {imem_req, instr_valid}, 2'b10);
        check("wait_addr", imem_addr, 16'h0033);
        mem_on = 1'b1;
        do_reset();
        exp_q.push_back(16'h0000);
        redirect(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        check("rst_stack_empty", {stack_underflow, halted}, 2'b11);

        repeat (2) @(negedge clk);
        check("scoreboard_final", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, number of return-address stack entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  16  word address of the requested instruction.
REQ-007 SHALL have port imem_valid  input  1  memory response strobe; imem_rdata valid this cycle.
REQ-008 SHALL have port imem_rdata  input  16  instruction word returned by memory.
REQ-009 SHALL have port instr  output  16  instruction presented to decode (control unit).
REQ-010 SHALL have port instr_pc  output  16  address of the presented instruction.
REQ-011 SHALL have port instr_valid  output  1  instr/instr_pc hold a live instruction.
REQ-012 SHALL have port stall  input  1  decode/execute not ready; presented instruction not consumed.
REQ-013 SHALL have ports jump_en, call_en, ret_en, halt_en  input  1 each  resolved redirect for the instruction being consumed; jump_en covers JMP and taken BEQ/BLT.
REQ-014 SHALL have port target  input  16  redirect address for jump_en/call_en.
REQ-015 SHALL have port halted  output  1  fetch permanently stopped until reset.
REQ-016 SHALL have ports stack_overflow, stack_underflow  output  1 each  sticky return-stack error flags.

Function
REQ-017 SHALL implement FSM states FETCH, HOLD, HALTED.
REQ-018 FETCH: imem_req=1, imem_addr=pc held stable every cycle until imem_valid; imem_valid -> register imem_rdata into instr, pc into instr_pc, go HOLD.
REQ-019 HOLD: instr_valid=1, imem_req=0; instruction consumed in the first HOLD cycle with stall=0.
REQ-020 Redirect inputs SHALL be sampled only in a consume cycle; ignored otherwise.
REQ-021 Consume priority: halt_en > ret_en > call_en > jump_en > sequential.
REQ-022 Sequential: next pc = instr_pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000); go FETCH.
REQ-023 jump_en: next pc = target; go FETCH.
REQ-024 call_en: push instr_pc + 1 (mod 2^16), next pc = target; go FETCH.
REQ-025 ret_en: pop top of stack into next pc; go FETCH.
REQ-026 halt_en: go HALTED; pc unchanged.
REQ-027 call_en with stack full (STACK_DEPTH entries): no push, stack_overflow=1, go HALTED.
REQ-028 ret_en with stack empty: no pop, stack_underflow=1, go HALTED.
REQ-029 HALTED: imem_req=0, instr_valid=0, halted=1; all inputs except rst ignored.
REQ-030 imem_valid outside FETCH SHALL be ignored.
REQ-031 At most one request outstanding; no speculative fetch past an unconsumed instruction.
REQ-032 Minimum throughput: one instruction per 2 cycles (FETCH with 0-wait response, HOLD with stall=0).
REQ-033 Stack is LIFO; stack pointer range 0..STACK_DEPTH; error flags sticky until reset.

Reset
REQ-034 rst=1 at an edge SHALL force: state FETCH, pc=RESET_PC, stack empty, instr=0, instr_pc=0, instr_valid=0, halted=0, stack_overflow=0, stack_underflow=0.
REQ-035 First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
REQ-036 rst asserted mid-fetch, in HOLD, or in HALTED SHALL abandon the pending request and discard the held instruction; memory is reset alongside fetch_unit.
REQ-037 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-038 Reset then imem_valid the cycle after each request, stall=0, no redirects -> instr_pc sequence 0,1,2,3; instr_valid every other cycle.
REQ-039 Instruction at pc 16'h0010 with stall=1 for 3 cycles then jump_en=1, target=16'h0040 -> instr/instr_pc stable for all 3 stalled cycles; next imem_addr=16'h0040; redirect ignored while stalled.
REQ-040 call_en at pc 16'h0005, target 16'h0100; ret_en at pc 16'h0102 -> fetch 16'h0100, then 16'h0006.
REQ-041 Nine nested calls with STACK_DEPTH=8 -> ninth sets stack_overflow=1, halted=1, imem_req=0; ret_en on empty stack after reset -> stack_underflow=1, halted=1.
REQ-042 Sequential consume at pc 16'hFFFF -> next imem_addr=16'h0000; halt_en with jump_en same cycle -> HALTED, no fetch issued.
REQ-043 rst pulsed while FETCH waits on imem_valid at pc 16'h0033 -> next cycle imem_addr=16'h0000, instr_valid=0, stack empty.
